alu_scheduler: RTL and testbench
================================

Name: alu_scheduler

Overview:
- Shares one combinational `alu` instance between two requesters, e.g. an execute slot and a multiply/accumulate helper.
- Round-robin arbiter with a valid/ready request channel per requester.
- Single shared response channel carrying a requester ID.
- Registered result, one-entry response buffer with backpressure, and a completed-operation counter.

Parameters:
- N, 8, operand/result width passed to `alu`.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  N  operand A, requester 0
- req0_b  in  N  operand B, requester 0
- req0_func  in  3  ALU function code (`alucodes`), requester 0
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 operation accepted this cycle
- req1_a  in  N  operand A, requester 1
- req1_b  in  N  operand B, requester 1
- req1_func  in  3  ALU function code, requester 1
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer takes the response this cycle
- rsp_id  out  1  requester that issued the buffered operation
- rsp_result  out  N  registered ALU result
- rsp_zf  out  1  registered ALU zero flag
- ops_done  out  CNT_W  count of responses consumed

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zf=0, ops_done=0.
  - last_grant=1, so requester 0 wins first.
  - State becomes IDLE.
  - An in-flight buffered response is discarded; no partial retire.
- States:
  - IDLE: buffer empty.
  - FULL: buffer holds a response, rsp_valid=1.
- can_accept = (state==IDLE) | (state==FULL & rsp_ready).
- Arbitration (combinational, per cycle):
  - Only one requester valid: it is selected.
  - Both valid: the one not equal to last_grant is selected.
  - reqX_ready = can_accept & selected==X. At most one ready is high; ready is never high without the matching valid.
- Accept (valid & ready at edge T):
  - ALU is driven by the selected requester's a/b/func.
  - result, ZF and the ID are registered into the buffer at T.
  - rsp_valid=1 from T onward (latency 1 cycle).
  - last_grant <= selected.
- Retire (rsp_valid & rsp_ready at edge T):
  - ops_done increments by 1, wrapping modulo 2^CNT_W.
  - If no accept at T: state -> IDLE, rsp_valid=0.
- Simultaneous retire and accept in FULL: buffer is overwritten with the new response, state stays FULL. Sustained throughput is 1 op/cycle.
- FULL & !rsp_ready:
  - Both readies are 0.
  - rsp_* held stable; no change while stalled.
- No idle requests: last_grant is unchanged and the ALU inputs are don't-care.
- Requester rules:
  - Must hold valid and payload stable until ready.
  - Dropping valid before ready is illegal; the bench asserts against it.
- Arithmetic:
  - Entirely the `alu`'s; no width extension.
  - RMLT semantics: A integer times B signed Q1.7.
- ZF captured as produced by `alu` for the selected operation.

Decomposition:
- Package `alu_sched_pkg`:
  - typedef sched_state_t {IDLE, FULL}.
  - typedef req_id_t (1 bit).
  - localparam NUM_REQ=2.
- Function codes stay in the existing `alucodes` defines; not duplicated.
- Sub-module: one `alu` instance (#(.N(N))).
- Arbiter kept inline. A separate `rr_arb2` is justified only if a third requester is added later.

Test Plan:
- Single op: req0 a=5, b=17, func=RADD; rsp_ready=1.
  -> req0_ready high in cycle 0; next cycle rsp_valid=1, rsp_id=0, rsp_result=22, rsp_zf=0, ops_done=1 after retire.
- Fixed-point: req1 a=20, b=8'hE0, func=RMLT -> rsp_result=8'hFB, rsp_id=1.
- Fixed-point: req1 a=8'h21, b=8'h90, func=RMLT -> rsp_result=8'hE3, rsp_id=1.
- Zero flag: req0 a=b=8'h90, func=RSUB -> rsp_result=0, rsp_zf=1.
- Fairness: both valid continuously, rsp_ready=1, req0 RA a=1, req1 RB b=2.
  - Response IDs alternate 0,1,0,1.
  - Results alternate 1,2; one response per cycle.
  - ops_done=4 after 4 retires.
- Backpressure: rsp_ready=0 for 3 cycles after the first accept.
  - rsp_* stable; both readies 0.
  - Raising rsp_ready retires and accepts the next op in the same cycle.
- Reset mid-op: assert reset while FULL with a result of 22.
  - Next cycle: rsp_valid=0, ops_done=0.
  - With both requesters valid, the first grant after reset goes to req0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types for the two-requester ALU scheduler.
package alu_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } sched_state_t;

  typedef logic req_id_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU; RMLT multiplies an integer A by a signed Q1.(N-1) fraction B.
`ifndef ALUCODES
`define ALUCODES
`define RA   3'd0
`define RB   3'd1
`define RADD 3'd2
`define RSUB 3'd3
`define RMLT 3'd4
`define RAND 3'd5
`define ROR  3'd6
`define RXOR 3'd7
`endif

module alu #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   func,
  output logic [N-1:0] result,
  output logic         zf
);

  logic signed [2*N-1:0] a_ext;
  logic signed [2*N-1:0] b_ext;
  logic signed [2*N-1:0] product;
  logic                  unused_product_msb;

  assign a_ext   = {{N{a[N-1]}}, a};
  assign b_ext   = {{N{b[N-1]}}, b};
  assign product = a_ext * b_ext;
  // Dropping the N-1 fraction bits of the Q1.(N-1) operand floors toward -inf.
  assign unused_product_msb = product[2*N-1];

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    result = '0;
    case (func)
      `RA:     result = a;
      `RB:     result = b;
      `RADD:   result = a + b;
      `RSUB:   result = a - b;
      `RMLT:   result = product[2*N-2:N-1];
      `RAND:   result = a & b;
      `ROR:    result = a | b;
      `RXOR:   result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zf = (result == '0);

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with a
// one-entry registered response buffer and a completed-operation counter.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic [2:0]       req0_func,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic [2:0]       req1_func,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [N-1:0]     rsp_result,
  output logic             rsp_zf,
  output logic [CNT_W-1:0] ops_done
);

  sched_state_t       state;
  sched_state_t       state_next;
  req_id_t            last_grant;
  req_id_t            sel;
  logic [NUM_REQ-1:0] req_valid;
  logic               can_accept;
  logic               accept;
  logic               retire;
  logic [N-1:0]       alu_a;
  logic [N-1:0]       alu_b;
  logic [2:0]         alu_func;
  logic [N-1:0]       alu_result;
  logic               alu_zf;

  assign req_valid = {req1_valid, req0_valid};

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = FULL;
      FULL:    if (retire && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid  = (state == FULL);
    can_accept = (state == IDLE) || ((state == FULL) && rsp_ready);
  end

  // With both requesters waiting, the one not granted last time wins.
  always_comb begin
    if (&req_valid) sel = ~last_grant;
    else            sel = req_valid[1];
  end

  assign accept     = can_accept && (|req_valid);
  assign retire     = rsp_valid && rsp_ready;
  assign req0_ready = accept && (sel == 1'b0);
  assign req1_ready = accept && (sel == 1'b1);

  assign alu_a    = sel ? req1_a    : req0_a;
  assign alu_b    = sel ? req1_b    : req0_b;
  assign alu_func = sel ? req1_func : req0_func;

  alu #(.N(N)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .func   (alu_func),
    .result (alu_result),
    .zf     (alu_zf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zf     <= 1'b0;
      last_grant <= 1'b1;
      ops_done   <= '0;
    end else begin
      if (accept) begin
        rsp_id     <= sel;
        rsp_result <= alu_result;
        rsp_zf     <= alu_zf;
        last_grant <= sel;
      end
      if (retire) ops_done <= ops_done + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed self-checking bench for alu_scheduler: single ops, Q1.7 multiply,
// zero flag, round-robin streaming, response backpressure and reset mid-op.
module tb_alu_scheduler;

  localparam int N     = 8;
  localparam int CNT_W = 16;

  localparam logic [2:0] C_RA   = 3'd0;
  localparam logic [2:0] C_RB   = 3'd1;
  localparam logic [2:0] C_RADD = 3'd2;
  localparam logic [2:0] C_RSUB = 3'd3;
  localparam logic [2:0] C_RMLT = 3'd4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [N-1:0]     req0_a = '0;
  logic [N-1:0]     req0_b = '0;
  logic [2:0]       req0_func = '0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [N-1:0]     req1_a = '0;
  logic [N-1:0]     req1_b = '0;
  logic [2:0]       req1_func = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_id;
  logic [N-1:0]     rsp_result;
  logic             rsp_zf;
  logic [CNT_W-1:0] ops_done;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_ops = '0;

  always #5 clk = ~clk;

  alu_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_func  (req0_func),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_func  (req1_func),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zf     (rsp_zf),
    .ops_done   (ops_done)
  );

  // Requesters may not withdraw an operation before it is accepted.
  logic p0v = 1'b0, p0r = 1'b0, p1v = 1'b0, p1r = 1'b0, prst = 1'b1;
  always @(posedge clk) begin
    if (!reset && !prst) begin
      if (p0v && !p0r && !req0_valid) $error("req0_valid withdrawn before req0_ready");
      if (p1v && !p1r && !req1_valid) $error("req1_valid withdrawn before req1_ready");
    end
    p0v  <= req0_valid;
    p0r  <= req0_ready;
    p1v  <= req1_valid;
    p1r  <= req1_ready;
    prst <= reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    n_cmp++; if (rsp_result !== 8'h00) begin n_bad++; $display("FAIL reset_rsp_result got=%h exp=00", rsp_result); end
    n_cmp++; if (rsp_zf !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_zf got=%b exp=0", rsp_zf); end
    n_cmp++; if (ops_done !== 16'd0) begin n_bad++; $display("FAIL reset_ops_done got=%0d exp=0", ops_done); end
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got=%b exp=00", {req1_ready, req0_ready}); end
    reset = 1'b0;
    exp_ops = '0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd17; req0_func = C_RADD; rsp_ready = 1'b1;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_bad++; $display("FAIL single_ready got=%b exp=01", {req1_ready, req0_ready}); end
    tick();
    req0_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_bad++; $display("FAIL single_rsp_id got=%b exp=0", rsp_id); end
    n_cmp++; if (rsp_result !== 8'd22) begin n_bad++; $display("FAIL single_rsp_result got=%0d exp=22", rsp_result); end
    n_cmp++; if (rsp_zf !== 1'b0) begin n_bad++; $display("FAIL single_rsp_zf got=%b exp=0", rsp_zf); end
    n_cmp++; if (ops_done !== exp_ops) begin n_bad++; $display("FAIL single_ops_before got=%0d exp=%0d", ops_done, exp_ops); end
    tick();
    exp_ops++;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_rsp_drained got=%b exp=0", rsp_valid); end
    n_cmp++; if (ops_done !== exp_ops) begin n_bad++; $display("FAIL single_ops_after got=%0d exp=%0d", ops_done, exp_ops); end
  endtask

  task automatic test_zero_flag();
    req0_valid = 1'b1; req0_a = 8'h90; req0_b = 8'h90; req0_func = C_RSUB; rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready got=%b exp=1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    n_cmp++; if (rsp_result !== 8'h00) begin n_bad++; $display("FAIL zero_rsp_result got=%h exp=00", rsp_result); end
    n_cmp++; if (rsp_zf !== 1'b1) begin n_bad++; $display("FAIL zero_rsp_zf got=%b exp=1", rsp_zf); end
    tick();
    exp_ops++;
    n_cmp++; if (ops_done !== exp_ops) begin n_bad++; $display("FAIL zero_ops got=%0d exp=%0d", ops_done, exp_ops); end
  endtask

  task automatic test_fixed_point();
    logic [N-1:0] va [2];
    logic [N-1:0] vb [2];
    logic [N-1:0] vr [2];
    va[0] = 8'd20;  vb[0] = 8'hE0; vr[0] = 8'hFB;  // 20 * -0.25
    va[1] = 8'h21;  vb[1] = 8'h90; vr[1] = 8'hE3;  // 33 * -0.875 floors to -29
    for (int i = 0; i < 2; i++) begin
      req1_valid = 1'b1; req1_a = va[i]; req1_b = vb[i]; req1_func = C_RMLT; rsp_ready = 1'b1;
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_bad++; $display("FAIL fixed%0d_ready got=%b exp=10", i, {req1_ready, req0_ready}); end
      tick();
      req1_valid = 1'b0;
      n_cmp++; if (rsp_id !== 1'b1) begin n_bad++; $display("FAIL fixed%0d_rsp_id got=%b exp=1", i, rsp_id); end
      n_cmp++; if (rsp_result !== vr[i]) begin n_bad++; $display("FAIL fixed%0d_rsp_result got=%h exp=%h", i, rsp_result, vr[i]); end
      n_cmp++; if (rsp_zf !== 1'b0) begin n_bad++; $display("FAIL fixed%0d_rsp_zf got=%b exp=0", i, rsp_zf); end
      tick();
      exp_ops++;
    end
    n_cmp++; if (ops_done !== exp_ops) begin n_bad++; $display("FAIL fixed_ops got=%0d exp=%0d", ops_done, exp_ops); end
  endtask

  // Last grant went to req1, so the stream starts with req0.
  task automatic test_back_to_back();
    req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd0; req0_func = C_RA;
    req1_valid = 1'b1; req1_a = 8'd0; req1_b = 8'd2; req1_func = C_RB;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== (k[0] ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr%0d_ready got=%b exp=%b", k, {req1_ready, req0_ready}, (k[0] ? 2'b10 : 2'b01)); end
      tick();
      if (k == 2) req0_valid = 1'b0;
      if (k == 3) req1_valid = 1'b0;
      if (k > 0) exp_ops++;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rr%0d_rsp_valid got=%b exp=1", k, rsp_valid); end
      n_cmp++; if (rsp_id !== k[0]) begin n_bad++; $display("FAIL rr%0d_rsp_id got=%b exp=%b", k, rsp_id, k[0]); end
      n_cmp++; if (rsp_result !== (k[0] ? 8'd2 : 8'd1)) begin n_bad++; $display("FAIL rr%0d_rsp_result got=%0d exp=%0d", k, rsp_result, (k[0] ? 2 : 1)); end
      n_cmp++; if (ops_done !== exp_ops) begin n_bad++; $display("FAIL rr%0d_ops got=%0d exp=%0d", k, ops_done, exp_ops); end
    end
    tick();
    exp_ops++;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rr_drained got=%b exp=0", rsp_valid); end
    n_cmp++; if (ops_done !== exp_ops) begin n_bad++; $display("FAIL rr_ops_final got=%0d exp=%0d", ops_done, exp_ops); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd17; req0_func = C_RADD;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first_ready got=%b exp=1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd4; req1_func = C_RSUB;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 8'd22}) begin n_bad++; $display("FAIL bp%0d_rsp got=v%b id%b r%0d exp=v1 id0 r22", c, rsp_valid, rsp_id, rsp_result); end
      n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_bad++; $display("FAIL bp%0d_ready got=%b exp=00", c, {req1_ready, req0_ready}); end
      n_cmp++; if (ops_done !== exp_ops) begin n_bad++; $display("FAIL bp%0d_ops got=%0d exp=%0d", c, ops_done, exp_ops); end
      if (c < 2) tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_bad++; $display("FAIL bp_release_ready got=%b exp=10", {req1_ready, req0_ready}); end
    tick();
    req1_valid = 1'b0;
    exp_ops++;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 8'd5}) begin n_bad++; $display("FAIL bp_next_rsp got=v%b id%b r%0d exp=v1 id1 r5", rsp_valid, rsp_id, rsp_result); end
    n_cmp++; if (ops_done !== exp_ops) begin n_bad++; $display("FAIL bp_ops got=%0d exp=%0d", ops_done, exp_ops); end
    tick();
    exp_ops++;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained got=%b exp=0", rsp_valid); end
    n_cmp++; if (ops_done !== exp_ops) begin n_bad++; $display("FAIL bp_ops_final got=%0d exp=%0d", ops_done, exp_ops); end
  endtask

  // The last grant before reset goes to req0, so a req0 win afterwards shows the grant history was reset.
  task automatic test_reset_mid_op();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd17; req0_func = C_RADD;
    tick();
    req0_valid = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_result} !== {1'b1, 8'd22}) begin n_bad++; $display("FAIL rst_pre got=v%b r%0d exp=v1 r22", rsp_valid, rsp_result); end
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd0; req0_func = C_RA;
    req1_valid = 1'b1; req1_a = 8'd0; req1_b = 8'd9; req1_func = C_RB;
    tick();
    exp_ops = '0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (ops_done !== 16'd0) begin n_bad++; $display("FAIL rst_ops got=%0d exp=0", ops_done); end
    n_cmp++; if (rsp_result !== 8'd0) begin n_bad++; $display("FAIL rst_rsp_result got=%0d exp=0", rsp_result); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_bad++; $display("FAIL rst_first_grant got=%b exp=01", {req1_ready, req0_ready}); end
    tick();
    req0_valid = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 8'd7}) begin n_bad++; $display("FAIL rst_op0 got=v%b id%b r%0d exp=v1 id0 r7", rsp_valid, rsp_id, rsp_result); end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_bad++; $display("FAIL rst_second_grant got=%b exp=10", {req1_ready, req0_ready}); end
    tick();
    req1_valid = 1'b0;
    exp_ops++;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 8'd9}) begin n_bad++; $display("FAIL rst_op1 got=v%b id%b r%0d exp=v1 id1 r9", rsp_valid, rsp_id, rsp_result); end
    n_cmp++; if (ops_done !== exp_ops) begin n_bad++; $display("FAIL rst_ops_mid got=%0d exp=%0d", ops_done, exp_ops); end
    tick();
    exp_ops++;
    n_cmp++; if (ops_done !== exp_ops) begin n_bad++; $display("FAIL rst_ops_final got=%0d exp=%0d", ops_done, exp_ops); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout sim_time=%0t limit=100000", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_single();
    test_zero_flag();
    test_fixed_point();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
